mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port op, input, 6, opcode from the instruction register; valid from DECODE onward.
REQ-004 SHALL have port fc, input, 6, funct field from the instruction register; valid from DECODE onward.
REQ-005 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-006 SHALL have outputs mem_read, mem_write, iord, ir_write, pc_write, branch, reg_write, reg_dst, mem_to_reg, alu_src_a (each 1 bit), with the usual multicycle datapath meaning.
REQ-007 SHALL have outputs alu_src_b, 2 bits (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2), and pc_src, 2 bits (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have outputs alu_control, 3 bits; instr_done, 1 bit, one-cycle retire pulse; illegal, 1 bit, sticky fault flag.

Function
REQ-009 SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, ADDI_EX, ADDI_WB, BEQ_EX, JUMP, ILLEGAL.
REQ-010 SHALL decode only: R-type op 000000 with fc add 100000, sub 100010, and 100100, or 100101, slt 101010; addi 001000; lw 100011; sw 101011; beq 000100; j 000010.
REQ-011 SHALL use alu_control codes: add 000, sub 001, and 010, or 011, slt 100, beq compare 101.
REQ-012 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=000, pc_src=00; ir_write and pc_write SHALL equal mem_ready; stay in FETCH until mem_ready=1, then go to DECODE.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_control=000 (branch target precompute); next state by op/fc: lw/sw to MEMADR, R-type to RTYPE_EX, addi to ADDI_EX, beq to BEQ_EX, j to JUMP, anything else to ILLEGAL.
REQ-014 MEMADR: alu_src_a=1, alu_src_b=10, alu_control=000; go to MEMRD for lw, MEMWR for sw.
REQ-015 MEMRD: mem_read=1, iord=1; wait while mem_ready=0; on mem_ready=1 go to MEMWB.
REQ-016 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; instr_done=1; then FETCH.
REQ-017 MEMWR: mem_write=1, iord=1, held until mem_ready=1; in that cycle instr_done=1; then FETCH.
REQ-018 RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_control from fc per REQ-011; then RTYPE_WB.
REQ-019 RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0; instr_done=1; then FETCH.
REQ-020 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_control=000; then ADDI_WB, which sets reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, then FETCH.
REQ-021 BEQ_EX: alu_src_a=1, alu_src_b=00, alu_control=101, branch=1, pc_src=01; instr_done=1; then FETCH.
REQ-022 JUMP: pc_write=1, pc_src=10; instr_done=1; then FETCH.
REQ-023 ILLEGAL: illegal=1, all write enables and mem_read=0; remain in ILLEGAL until reset.
REQ-024 Any output not named for a state SHALL be 0 in that state.
REQ-025 Throughput SHALL be: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3, each plus memory wait cycles.
REQ-026 op/fc SHALL be sampled only in DECODE and RTYPE_EX; changes in other states SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL force state=FETCH immediately, independent of clk, including mid-instruction and during memory waits.
REQ-028 Reset values: mem_read=1, alu_src_b=01, all other outputs 0, and illegal cleared; ir_write and pc_write follow mem_ready only after rst_n deasserts.

Structure
REQ-029 A shared package mc_pkg SHALL hold the state enum, opcode/funct constants, and ALU code constants used here and by the ALU.
REQ-030 Funct-to-alu_control mapping SHALL be one combinational sub-module, mc_alu_decoder.

Verification
REQ-031 add (op 000000, fc 100000) with mem_ready=1 -> states FETCH, DECODE, RTYPE_EX, RTYPE_WB; alu_control=000 in EX; reg_write=1, reg_dst=1 and instr_done=1 in cycle 4.
REQ-032 lw with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, no reg_write until MEMWB; total 8 cycles.
REQ-033 sw -> mem_write=1 and iord=1 held until mem_ready=1; no reg_write at any point; instr_done pulses once.
REQ-034 beq -> alu_control=101, branch=1, pc_src=01 in cycle 3; j -> pc_write=1, pc_src=10 in cycle 3.
REQ-035 op 111111 -> ILLEGAL after DECODE; illegal stays 1 for 10+ cycles with no writes; rst_n=0 clears it and returns to FETCH.
REQ-036 rst_n=0 asserted mid-MEMWR -> mem_write drops without waiting for clk; FETCH outputs per REQ-028.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller and the ALU.
package mc_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FC_W   = 6;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BEQ_EX   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_e;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [FC_W-1:0] FC_ADD = 6'b100000;
    localparam logic [FC_W-1:0] FC_SUB = 6'b100010;
    localparam logic [FC_W-1:0] FC_AND = 6'b100100;
    localparam logic [FC_W-1:0] FC_OR  = 6'b100101;
    localparam logic [FC_W-1:0] FC_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b100;
    localparam logic [ALU_W-1:0] ALU_BEQ = 3'b101;

    // ALU B-operand and PC source selects
    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Full control word driven toward the datapath
    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              iord;
        logic              ir_write;
        logic              pc_write;
        logic              branch;
        logic              reg_write;
        logic              reg_dst;
        logic              mem_to_reg;
        logic              alu_src_a;
        logic [SEL_W-1:0]  alu_src_b;
        logic [SEL_W-1:0]  pc_src;
        logic [ALU_W-1:0]  alu_control;
        logic              instr_done;
        logic              illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory signal bundle.
interface mc_control_fsm_if;
    import mc_pkg::*;

    logic [OP_W-1:0]  op;
    logic [FC_W-1:0]  fc;
    logic             mem_ready;

    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] pc_src;
    logic [ALU_W-1:0] alu_control;
    logic             instr_done;
    logic             illegal;

    // Controller side
    modport master (
        input  op, fc, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, branch,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               pc_src, alu_control, instr_done, illegal
    );

    // Datapath / memory side
    modport slave (
        output op, fc, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, branch,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               pc_src, alu_control, instr_done, illegal
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// Funct field to ALU operation mapping for R-type instructions.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [FC_W-1:0]  fc_i,
    output logic [ALU_W-1:0] alu_ctrl_c_o,
    output logic             fc_legal_c_o
);

    // Map funct to ALU code; flag unsupported functs
    always_comb begin
        alu_ctrl_c_o = ALU_ADD;
        fc_legal_c_o = 1'b1;
        case (fc_i)
            FC_ADD:  alu_ctrl_c_o = ALU_ADD;
            FC_SUB:  alu_ctrl_c_o = ALU_SUB;
            FC_AND:  alu_ctrl_c_o = ALU_AND;
            FC_OR:   alu_ctrl_c_o = ALU_OR;
            FC_SLT:  alu_ctrl_c_o = ALU_SLT;
            default: fc_legal_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle processor control FSM. Control outputs are decoded from the
// registered state so an asynchronous reset changes them immediately.
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);

    state_e           state_q, state_d;
    logic             is_sw_q, is_sw_d;
    ctrl_t            ctrl_c;
    logic [ALU_W-1:0] rtype_alu_c;
    logic             fc_legal_c;

    mc_alu_decoder u_alu_dec (
        .fc_i         (bus.fc),
        .alu_ctrl_c_o (rtype_alu_c),
        .fc_legal_c_o (fc_legal_c)
    );

    // State and lw/sw selector registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    // Next-state and control-word decode
    always_comb begin
        state_d = state_q;
        is_sw_d = is_sw_q;
        ctrl_c  = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read    = 1'b1;
                ctrl_c.alu_src_b   = SRCB_FOUR;
                ctrl_c.alu_control = ALU_ADD;
                ctrl_c.pc_src      = PCSRC_ALU;
                // Writes are held off while reset is still asserted
                ctrl_c.ir_write    = bus.mem_ready & rst_n;
                ctrl_c.pc_write    = bus.mem_ready & rst_n;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b   = SRCB_IMM_SH;
                ctrl_c.alu_control = ALU_ADD;
                // lw/sw choice is latched here so later op changes are ignored
                case (bus.op)
                    OP_LW: begin
                        state_d = S_MEMADR;
                        is_sw_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d = S_MEMADR;
                        is_sw_d = 1'b1;
                    end
                    OP_RTYPE: state_d = fc_legal_c ? S_RTYPE_EX : S_ILLEGAL;
                    OP_ADDI:  state_d = S_ADDI_EX;
                    OP_BEQ:   state_d = S_BEQ_EX;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a   = 1'b1;
                ctrl_c.alu_src_b   = SRCB_IMM;
                ctrl_c.alu_control = ALU_ADD;
                state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_c.mem_write  = 1'b1;
                ctrl_c.iord       = 1'b1;
                ctrl_c.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_RTYPE_EX: begin
                ctrl_c.alu_src_a   = 1'b1;
                ctrl_c.alu_src_b   = SRCB_REG;
                ctrl_c.alu_control = rtype_alu_c;
                state_d = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDI_EX: begin
                ctrl_c.alu_src_a   = 1'b1;
                ctrl_c.alu_src_b   = SRCB_IMM;
                ctrl_c.alu_control = ALU_ADD;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ_EX: begin
                ctrl_c.alu_src_a   = 1'b1;
                ctrl_c.alu_src_b   = SRCB_REG;
                ctrl_c.alu_control = ALU_BEQ;
                ctrl_c.branch      = 1'b1;
                ctrl_c.pc_src      = PCSRC_ALUOUT;
                ctrl_c.instr_done  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.pc_src     = PCSRC_JUMP;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl_c.illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Drive the control word onto the bus
    assign bus.mem_read    = ctrl_c.mem_read;
    assign bus.mem_write   = ctrl_c.mem_write;
    assign bus.iord        = ctrl_c.iord;
    assign bus.ir_write    = ctrl_c.ir_write;
    assign bus.pc_write    = ctrl_c.pc_write;
    assign bus.branch      = ctrl_c.branch;
    assign bus.reg_write   = ctrl_c.reg_write;
    assign bus.reg_dst     = ctrl_c.reg_dst;
    assign bus.mem_to_reg  = ctrl_c.mem_to_reg;
    assign bus.alu_src_a   = ctrl_c.alu_src_a;
    assign bus.alu_src_b   = ctrl_c.alu_src_b;
    assign bus.pc_src      = ctrl_c.pc_src;
    assign bus.alu_control = ctrl_c.alu_control;
    assign bus.instr_done  = ctrl_c.instr_done;
    assign bus.illegal     = ctrl_c.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle vector table plus reset
// and illegal-opcode sequences.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mc_control_fsm_if bus();

    mc_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output word: mr mw iord irw pcw br rw rd m2r sa | sb(2) ps(2) alu(3) done ill
    localparam logic [18:0] E_FW   = 19'b1_0_0_0_0_0_0_0_0_0_01_00_000_0_0;
    localparam logic [18:0] E_FR   = 19'b1_0_0_1_1_0_0_0_0_0_01_00_000_0_0;
    localparam logic [18:0] E_DEC  = 19'b0_0_0_0_0_0_0_0_0_0_11_00_000_0_0;
    localparam logic [18:0] E_MADR = 19'b0_0_0_0_0_0_0_0_0_1_10_00_000_0_0;
    localparam logic [18:0] E_MRD  = 19'b1_0_1_0_0_0_0_0_0_0_00_00_000_0_0;
    localparam logic [18:0] E_MWB  = 19'b0_0_0_0_0_0_1_0_1_0_00_00_000_1_0;
    localparam logic [18:0] E_MWRW = 19'b0_1_1_0_0_0_0_0_0_0_00_00_000_0_0;
    localparam logic [18:0] E_MWRD = 19'b0_1_1_0_0_0_0_0_0_0_00_00_000_1_0;
    localparam logic [18:0] E_RWB  = 19'b0_0_0_0_0_0_1_1_0_0_00_00_000_1_0;
    localparam logic [18:0] E_AWB  = 19'b0_0_0_0_0_0_1_0_0_0_00_00_000_1_0;
    localparam logic [18:0] E_BEQ  = 19'b0_0_0_0_0_1_0_0_0_1_00_01_101_1_0;
    localparam logic [18:0] E_JMP  = 19'b0_0_0_0_1_0_0_0_0_0_00_10_000_1_0;
    localparam logic [18:0] E_ILL  = 19'b0_0_0_0_0_0_0_0_0_0_00_00_000_0_1;

    localparam logic [5:0] XX = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fc;
        logic        mr;
        logic [18:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [18:0] e_rex(input logic [2:0] a);
        return {10'b0000000001, 2'b00, 2'b00, a, 2'b00};
    endfunction

    function automatic logic [18:0] got_word();
        return {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                bus.branch, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.pc_src, bus.alu_control, bus.instr_done, bus.illegal};
    endfunction

    task automatic add_vec(input logic [5:0] op, input logic [5:0] fc, input logic mr,
                           input logic [18:0] exp, input string name);
        vec_t v;
        v.op = op; v.fc = fc; v.mr = mr; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [18:0] exp);
        logic [18:0] got;
        got = got_word();
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b required %b", name, got, exp);
    endtask

    // Drive inputs mid-low-phase and check before the next rising edge
    task automatic apply(input logic [5:0] op, input logic [5:0] fc, input logic mr,
                         input logic [18:0] exp, input string name);
        @(negedge clk);
        bus.op = op; bus.fc = fc; bus.mem_ready = mr;
        #1 chk(name, exp);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic mid_reset(input logic mr, input string name);
        bus.mem_ready = mr;
        #1 rst_n = 1'b0;
        #1 chk(name, E_FW);
        #1 rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #0 chk({name, "_rel"}, E_FW);
    endtask

    initial begin
        bus.op = XX; bus.fc = XX; bus.mem_ready = 1'b1;

        // add, sub, and, or, slt; op scrambled outside sampling states
        add_vec(XX,     XX,     1, E_FR,          "add_fetch");
        add_vec(6'h00,  6'h20,  1, E_DEC,         "add_dec");
        add_vec(6'h00,  6'h20,  1, e_rex(3'b000), "add_ex");
        add_vec(XX,     XX,     1, E_RWB,         "add_wb");
        add_vec(XX,     XX,     1, E_FR,          "sub_fetch");
        add_vec(6'h00,  6'h22,  1, E_DEC,         "sub_dec");
        add_vec(6'h00,  6'h22,  1, e_rex(3'b001), "sub_ex");
        add_vec(XX,     XX,     1, E_RWB,         "sub_wb");
        add_vec(XX,     XX,     1, E_FR,          "and_fetch");
        add_vec(6'h00,  6'h24,  1, E_DEC,         "and_dec");
        add_vec(6'h00,  6'h24,  1, e_rex(3'b010), "and_ex");
        add_vec(XX,     XX,     1, E_RWB,         "and_wb");
        add_vec(XX,     XX,     1, E_FR,          "or_fetch");
        add_vec(6'h00,  6'h25,  1, E_DEC,         "or_dec");
        add_vec(6'h00,  6'h25,  1, e_rex(3'b011), "or_ex");
        add_vec(XX,     XX,     1, E_RWB,         "or_wb");
        add_vec(XX,     XX,     1, E_FR,          "slt_fetch");
        add_vec(6'h00,  6'h2A,  1, E_DEC,         "slt_dec");
        add_vec(6'h00,  6'h2A,  1, e_rex(3'b100), "slt_ex");
        add_vec(XX,     XX,     1, E_RWB,         "slt_wb");
        // addi
        add_vec(XX,     XX,     1, E_FR,          "addi_fetch");
        add_vec(6'h08,  XX,     1, E_DEC,         "addi_dec");
        add_vec(XX,     XX,     1, E_MADR,        "addi_ex");
        add_vec(XX,     XX,     1, E_AWB,         "addi_wb");
        // lw with fetch wait and 3 memory wait cycles; op flipped to sw in MEMADR
        add_vec(XX,     XX,     0, E_FW,          "lw_fetch_wait");
        add_vec(XX,     XX,     1, E_FR,          "lw_fetch");
        add_vec(6'h23,  XX,     1, E_DEC,         "lw_dec");
        add_vec(6'h2B,  XX,     1, E_MADR,        "lw_madr");
        add_vec(6'h2B,  XX,     0, E_MRD,         "lw_rd_w1");
        add_vec(XX,     XX,     0, E_MRD,         "lw_rd_w2");
        add_vec(XX,     XX,     0, E_MRD,         "lw_rd_w3");
        add_vec(XX,     XX,     1, E_MRD,         "lw_rd_go");
        add_vec(XX,     XX,     0, E_MWB,         "lw_wb");
        // sw with 2 wait cycles
        add_vec(XX,     XX,     1, E_FR,          "sw_fetch");
        add_vec(6'h2B,  XX,     1, E_DEC,         "sw_dec");
        add_vec(6'h23,  XX,     1, E_MADR,        "sw_madr");
        add_vec(XX,     XX,     0, E_MWRW,        "sw_wr_w1");
        add_vec(XX,     XX,     0, E_MWRW,        "sw_wr_w2");
        add_vec(XX,     XX,     1, E_MWRD,        "sw_wr_go");
        // beq, j
        add_vec(XX,     XX,     1, E_FR,          "beq_fetch");
        add_vec(6'h04,  XX,     1, E_DEC,         "beq_dec");
        add_vec(XX,     XX,     1, E_BEQ,         "beq_ex");
        add_vec(XX,     XX,     1, E_FR,          "j_fetch");
        add_vec(6'h02,  XX,     1, E_DEC,         "j_dec");
        add_vec(XX,     XX,     1, E_JMP,         "j_ex");
        // R-type with unsupported funct
        add_vec(XX,     XX,     1, E_FR,          "badfc_fetch");
        add_vec(6'h00,  6'h00,  1, E_DEC,         "badfc_dec");
        add_vec(6'h00,  6'h20,  1, E_ILL,         "badfc_ill1");
        add_vec(6'h02,  XX,     1, E_ILL,         "badfc_ill2");

        // Reset state: ir/pc writes gated even with mem_ready high
        @(negedge clk);
        @(negedge clk);
        #1 chk("reset_state", E_FW);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1 chk("post_reset_idle", E_FW);

        foreach (vecs[i]) apply(vecs[i].op, vecs[i].fc, vecs[i].mr, vecs[i].exp, vecs[i].name);

        mid_reset(1'b1, "rst_from_badfc");

        // Undefined opcode: sticky illegal for 12 cycles, then async reset
        apply(XX, XX, 1, E_FR,  "ill_fetch");
        apply(XX, XX, 1, E_DEC, "ill_dec");
        for (int k = 0; k < 12; k++)
            apply((k % 2 == 0) ? 6'h02 : 6'h23, 6'h20, 1'(k % 2), E_ILL, "ill_hold");
        mid_reset(1'b1, "rst_from_ill");

        // Async reset in the middle of a memory write wait
        apply(XX,    XX, 1, E_FR,   "rw_fetch");
        apply(6'h2B, XX, 1, E_DEC,  "rw_dec");
        apply(XX,    XX, 1, E_MADR, "rw_madr");
        apply(XX,    XX, 0, E_MWRW, "rw_wait");
        mid_reset(1'b1, "rst_mid_memwr");
        apply(XX,    XX, 1, E_FR,   "rw_refetch");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
